// File: rtl/dcache_mem_responder_pkg.sv
// ---- cache_defs: shared dcache/memory request, response and responder types ----
// Rev 1.0
`default_nettype none

package cache_defs;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dcache2mem_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_mem2dcache_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } resp_state_e;

  localparam logic [31:0] DEFAULT_FILL_PATTERN = 32'hAAAA_AAAA;

endpackage

`default_nettype wire

// File: rtl/dcache_mem_responder_if.sv
// ---- dcache_mem_responder_if: dcache <-> memory responder request/response bundle ----
// Rev 1.0
`default_nettype none

interface dcache_mem_responder_if;

  cache_defs::type_dcache2mem_s dcache2mem_i;
  logic                         dcache2mem_kill_i;
  cache_defs::type_mem2dcache_s mem2dcache_o;

  modport master (
    output dcache2mem_i,
    output dcache2mem_kill_i,
    input  mem2dcache_o
  );

  modport slave (
    input  dcache2mem_i,
    input  dcache2mem_kill_i,
    output mem2dcache_o
  );

endinterface

`default_nettype wire

// File: rtl/dcache_mem_responder_sram.sv
// ---- mem_resp_sram: word storage with per-word valid bits, sync write, comb read ----
// Rev 1.0
`default_nettype none

module mem_resp_sram #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int IDX_W           = $clog2(MEM_DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic             rd_valid
);

  logic [31:0]                data_array [MEM_DEPTH_WORDS];
  logic [MEM_DEPTH_WORDS-1:0] valid_bits;

  // Data contents survive reset; only the valid bits define what has been written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_array[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_idx] <= 1'b1;
    end
  end

  assign rd_data  = data_array[rd_idx];
  assign rd_valid = valid_bits[rd_idx];

endmodule

`default_nettype wire

// File: rtl/dcache_mem_responder.sv
// ---- dcache_mem_responder: fixed-latency single-outstanding memory model for the dcache ----
// Rev 1.0
`default_nettype none

module dcache_mem_responder
  import cache_defs::*;
#(
  parameter int          MEM_DEPTH_WORDS = 1024,
  parameter int          ACK_LATENCY     = 2,
  parameter logic [31:0] FILL_PATTERN    = DEFAULT_FILL_PATTERN
) (
  input logic                   clk,
  input logic                   rst_n,
  dcache_mem_responder_if.slave bus
);

  localparam int         IDX_W   = $clog2(MEM_DEPTH_WORDS);
  localparam logic [3:0] LATENCY = 4'(ACK_LATENCY);

  resp_state_e      state;
  logic [3:0]       count;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_data;
  logic             cap_wen;
  logic             ack;

  type_dcache2mem_s req_in;
  type_mem2dcache_s resp;
  logic             wr_fire;
  logic [31:0]      rd_word;
  logic             rd_valid;
  logic             unused_addr_bits;

  assign req_in = bus.dcache2mem_i;
  // The word index wraps: high address bits and byte offset alias onto the same word.
  assign unused_addr_bits = ^{req_in.addr[31:IDX_W+2], req_in.addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 4'd0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in.req) begin
            cap_idx  <= req_in.addr[IDX_W+1:2];
            cap_data <= req_in.w_data;
            cap_wen  <= req_in.w_en;
            count    <= LATENCY;
            if (LATENCY == 4'd0) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.dcache2mem_kill_i) begin
            state <= IDLE;
            count <= 4'd0;
          end else if (count == 4'd1) begin
            state <= ACK;
            ack   <= 1'b1;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        ACK:     state <= DONE;
        // DONE swallows one cycle so a req held high is not re-captured immediately.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_fire = rst_n && (state == ACK) && cap_wen;

  mem_resp_sram #(
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS),
    .IDX_W          (IDX_W)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire),
    .wr_idx  (cap_idx),
    .wr_data (cap_data),
    .rd_idx  (cap_idx),
    .rd_data (rd_word),
    .rd_valid(rd_valid)
  );

  always_comb begin
    resp     = '0;
    resp.ack = ack;
    if (ack && !cap_wen) begin
      resp.r_data = rd_valid ? rd_word : FILL_PATTERN;
    end
  end

  assign bus.mem2dcache_o = resp;

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_responder.sv
// ---- tb_dcache_mem_responder: directed stimulus, cycle-level reference model, per-cycle compare ----
// Rev 1.0
`default_nettype none

module tb_dcache_mem_responder;
  import cache_defs::*;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] FILL  = 32'hAAAA_AAAA;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_mem_responder_if bus();
  dcache_mem_responder_if bus0();

  dcache_mem_responder #(
    .MEM_DEPTH_WORDS(DEPTH),
    .ACK_LATENCY    (LAT),
    .FILL_PATTERN   (FILL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  dcache_mem_responder #(
    .MEM_DEPTH_WORDS(16),
    .ACK_LATENCY    (0)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: reasons in absolute edge numbers rather than FSM states.
  int          cyc         = 0;
  bit          started     = 1'b0;
  bit          pending     = 1'b0;
  int          cap         = 0;
  int          next_accept = 0;
  bit          m_we        = 1'b0;
  int unsigned m_idx       = 0;
  logic [31:0] m_wd        = '0;
  logic [31:0] mem_model [int unsigned];
  bit          exp_ack     = 1'b0;
  logic [31:0] exp_rd      = '0;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (!rst_n) begin
      pending     = 1'b0;
      mem_model.delete();
      exp_ack     = 1'b0;
      exp_rd      = '0;
      next_accept = 0;
    end else begin
      if (exp_ack && m_we) mem_model[m_idx] = m_wd;
      exp_ack = 1'b0;
      exp_rd  = '0;
      if (pending && bus.dcache2mem_kill_i && cyc > cap && cyc <= cap + LAT) begin
        pending     = 1'b0;
        next_accept = cyc + 1;
      end
      if (!pending && cyc >= next_accept && bus.dcache2mem_i.req) begin
        pending     = 1'b1;
        cap         = cyc;
        next_accept = cyc + LAT + 3;
        m_we        = bus.dcache2mem_i.w_en;
        m_idx       = (bus.dcache2mem_i.addr >> 2) % DEPTH;
        m_wd        = bus.dcache2mem_i.w_data;
      end
      if (pending && cyc == cap + LAT) begin
        pending = 1'b0;
        exp_ack = 1'b1;
        exp_rd  = m_we ? 32'h0 : (mem_model.exists(m_idx) ? mem_model[m_idx] : FILL);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ack", {31'b0, bus.mem2dcache_o.ack}, {31'b0, exp_ack});
      check("r_data", bus.mem2dcache_o.r_data, exp_rd);
    end
  end

  // Issue one request, scramble the request bus after capture, wait for the ack.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                         input logic kill_in_ack, output logic [31:0] rd, output int lat);
    int c;
    bit seen;
    seen = 1'b0;
    rd   = '0;
    lat  = -1;
    bus.dcache2mem_i.addr   = addr;
    bus.dcache2mem_i.w_data = wd;
    bus.dcache2mem_i.w_en   = we;
    bus.dcache2mem_i.req    = 1'b1;
    tick();
    c = cyc;
    bus.dcache2mem_i.req    = 1'b0;
    bus.dcache2mem_i.addr   = $urandom;
    bus.dcache2mem_i.w_data = $urandom;
    bus.dcache2mem_i.w_en   = 1'($urandom_range(0, 1));
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem2dcache_o.ack) begin
        seen = 1'b1;
        rd   = bus.mem2dcache_o.r_data;
        lat  = cyc + 1 - c;
      end
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    if (kill_in_ack) bus.dcache2mem_kill_i = 1'b1;
    tick();
    bus.dcache2mem_kill_i = 1'b0;
    tick();
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.mem2dcache_o.ack) acks++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          acks;
    int          n;
    int          last;
    int          consec;
    bit          prev;

    bus.dcache2mem_i       = '0;
    bus.dcache2mem_kill_i  = 1'b0;
    bus0.dcache2mem_i      = '0;
    bus0.dcache2mem_kill_i = 1'b0;

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_ack", {31'b0, bus.mem2dcache_o.ack}, 32'd0);
    check("reset_rdata", bus.mem2dcache_o.r_data, 32'd0);
    rst_n = 1'b1;

    run_txn(32'h0001_0010, 32'h0, 1'b0, 1'b0, rd, lat);
    check("first_read_latency", lat, 32'd3);
    check("first_read_fill", rd, 32'hAAAA_AAAA);

    run_txn(32'h0000_1010, 32'hDEAD_BEEF, 1'b1, 1'b0, rd, lat);
    check("write_ack_rdata_zero", rd, 32'h0);
    run_txn(32'h0000_1010, 32'h0, 1'b0, 1'b0, rd, lat);
    check("readback_deadbeef", rd, 32'hDEAD_BEEF);

    run_txn(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, rd, lat);
    run_txn(32'(4 * DEPTH), 32'h0, 1'b0, 1'b0, rd, lat);
    check("alias_readback", rd, 32'h1234_5678);

    // Kill one cycle after capture: no ack, no write.
    bus.dcache2mem_i.addr   = 32'h0000_0040;
    bus.dcache2mem_i.w_data = 32'h5555_5555;
    bus.dcache2mem_i.w_en   = 1'b1;
    bus.dcache2mem_i.req    = 1'b1;
    tick();
    bus.dcache2mem_i.req  = 1'b0;
    bus.dcache2mem_kill_i = 1'b1;
    tick();
    bus.dcache2mem_kill_i = 1'b0;
    count_acks(8, acks);
    check("kill_no_ack", acks, 32'd0);
    run_txn(32'h0000_0040, 32'h0, 1'b0, 1'b0, rd, lat);
    check("kill_no_write", rd, 32'hAAAA_AAAA);

    // Kill during the ack cycle is ignored.
    run_txn(32'h0000_0080, 32'h0BAD_F00D, 1'b1, 1'b1, rd, lat);
    run_txn(32'h0000_0080, 32'h0, 1'b0, 1'b0, rd, lat);
    check("kill_in_ack_write_kept", rd, 32'h0BAD_F00D);

    // Reset clears valid bits.
    run_txn(32'h0000_0100, 32'hCAFE_F00D, 1'b1, 1'b0, rd, lat);
    run_txn(32'h0000_0100, 32'h0, 1'b0, 1'b0, rd, lat);
    check("cafe_before_reset", rd, 32'hCAFE_F00D);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_txn(32'h0000_0100, 32'h0, 1'b0, 1'b0, rd, lat);
    check("reset_clears_valid", rd, 32'hAAAA_AAAA);

    // Reset while waiting aborts the transaction.
    bus.dcache2mem_i.addr   = 32'h0000_0200;
    bus.dcache2mem_i.w_data = 32'h7777_7777;
    bus.dcache2mem_i.w_en   = 1'b1;
    bus.dcache2mem_i.req    = 1'b1;
    tick();
    bus.dcache2mem_i.req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_acks(8, acks);
    check("reset_in_wait_no_ack", acks, 32'd0);
    run_txn(32'h0000_0200, 32'h0, 1'b0, 1'b0, rd, lat);
    check("reset_in_wait_no_write", rd, 32'hAAAA_AAAA);

    // Zero-latency responder with req held high for 20 cycles.
    bus0.dcache2mem_i.addr = 32'h0000_0004;
    bus0.dcache2mem_i.w_en = 1'b0;
    bus0.dcache2mem_i.req  = 1'b1;
    n      = 0;
    last   = -1;
    consec = 0;
    prev   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.mem2dcache_o.ack) begin
        n++;
        if (prev) consec++;
        check("held_rdata", bus0.mem2dcache_o.r_data, 32'hAAAA_AAAA);
        if (last >= 0) check("held_gap", i - last, 32'd3);
        last = i;
      end
      prev = bus0.mem2dcache_o.ack;
    end
    bus0.dcache2mem_i.req = 1'b0;
    check("held_ack_count", n, 32'd7);
    check("held_no_consecutive", consec, 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
